// File: rtl/alu_nibble_sequencer_if.sv
// alu_nibble_sequencer_if: command and result valid/ready bundle between the
// front end (master) and the nibble sequencer (slave).
interface alu_nibble_sequencer_if #(parameter int NIBBLES = 4);
    localparam int W = 4 * NIBBLES;
    logic         op_valid;
    logic         op_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [3:0]   op_s;
    logic         op_m;
    logic         op_cnb;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_f;
    logic         res_cn4b;
    logic         res_aeb;
    modport master (
        output op_valid, op_a, op_b, op_s, op_m, op_cnb, res_ready,
        input  op_ready, res_valid, res_f, res_cn4b, res_aeb
    );
    modport slave (
        input  op_valid, op_a, op_b, op_s, op_m, op_cnb, res_ready,
        output op_ready, res_valid, res_f, res_cn4b, res_aeb
    );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: runs a wide 74181-style operation one nibble per clock
// through a single combinational slice, LSB nibble first, chaining carry.
module alu_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_nibble_sequencer_if.slave bus,
    output logic [3:0]            alu_a,
    output logic [3:0]            alu_b,
    output logic [3:0]            alu_s,
    output logic                  alu_m,
    output logic                  alu_cnb,
    input  logic [3:0]            alu_f,
    input  logic                  alu_cn4b,
    input  logic                  alu_aeb
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, f_q, f_d;
    logic [3:0]    s_q, s_d;
    logic          m_q, m_d, carry_q, carry_d, aeb_q, aeb_d;
    logic          cn4b_q, cn4b_d, raeb_q, raeb_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          run, last;
    assign run  = state_q == RUN;
    assign last = idx_q == IW'(NIBBLES - 1);
    // Slice sees a neutral logic-mode drive whenever no operation is in flight.
    assign alu_a   = run ? a_q[4*idx_q +: 4] : 4'h0;
    assign alu_b   = run ? b_q[4*idx_q +: 4] : 4'h0;
    assign alu_s   = run ? s_q : 4'h0;
    assign alu_m   = run ? m_q : 1'b1;
    assign alu_cnb = run ? carry_q : 1'b1;
    assign bus.op_ready  = state_q == IDLE;
    assign bus.res_valid = state_q == DONE;
    assign bus.res_f     = f_q;
    assign bus.res_cn4b  = cn4b_q;
    assign bus.res_aeb   = raeb_q;
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        m_d     = m_q;
        carry_d = carry_q;
        aeb_d   = aeb_q;
        idx_d   = idx_q;
        f_d     = f_q;
        cn4b_d  = cn4b_q;
        raeb_d  = raeb_q;
        case (state_q)
            IDLE: if (bus.op_valid) begin
                a_d     = bus.op_a;
                b_d     = bus.op_b;
                s_d     = bus.op_s;
                m_d     = bus.op_m;
                carry_d = bus.op_cnb;
                idx_d   = '0;
                aeb_d   = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                f_d[4*idx_q +: 4] = alu_f;
                carry_d = alu_cn4b;
                aeb_d   = aeb_q & alu_aeb;
                idx_d   = idx_q + 1'b1;
                if (last) begin
                    cn4b_d  = alu_cn4b;
                    raeb_d  = aeb_q & alu_aeb;
                    state_d = DONE;
                end
            end
            DONE: if (bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            m_q     <= 1'b0;
            carry_q <= 1'b1;
            aeb_q   <= 1'b0;
            idx_q   <= '0;
            f_q     <= '0;
            cn4b_q  <= 1'b1;
            raeb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            m_q     <= m_d;
            carry_q <= carry_d;
            aeb_q   <= aeb_d;
            idx_q   <= idx_d;
            f_q     <= f_d;
            cn4b_q  <= cn4b_d;
            raeb_q  <= raeb_d;
        end
    end
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// tb_alu_nibble_sequencer: directed bench with a behavioural 74181 slice and a
// wide-word reference model feeding an expected-result queue.
module tb_alu_nibble_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] alu_a, alu_b, alu_s, alu_f;
    logic alu_m, alu_cnb, alu_cn4b, alu_aeb;
    int vectors = 0;
    int errors = 0;
    logic [17:0] sb[$];
    logic [3:0] cnbs;
    logic [15:0] held;

    alu_nibble_sequencer_if #(.NIBBLES(4)) bus ();

    alu_nibble_sequencer #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cnb(alu_cnb),
        .alu_f(alu_f), .alu_cn4b(alu_cn4b), .alu_aeb(alu_aeb)
    );

    always #5 clk = ~clk;

    // 74181 slice: arithmetic is X plus Y plus carry, logic is ~(X ^ Y)
    always_comb begin
        logic [3:0] x, y;
        logic [4:0] sum;
        x = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
        y = (alu_a & ~alu_b & {4{alu_s[2]}}) | (alu_a & alu_b & {4{alu_s[3]}});
        sum = {1'b0, x} + {1'b0, y} + {4'b0, ~alu_cnb};
        alu_f = alu_m ? ~(x ^ y) : sum[3:0];
        alu_cn4b = ~sum[4];
        alu_aeb = &alu_f;
    end

    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] s, input logic m, input logic cnb);
        logic [15:0] x, y, f;
        logic [16:0] sum;
        x = a | (b & {16{s[0]}}) | (~b & {16{s[1]}});
        y = (a & ~b & {16{s[2]}}) | (a & b & {16{s[3]}});
        sum = {1'b0, x} + {1'b0, y} + {16'b0, ~cnb};
        f = m ? ~(x ^ y) : sum[15:0];
        return {f, ~sum[16], &f};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                         input logic m, input logic cnb);
        int n = 0;
        @(negedge clk);
        while (!bus.op_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("op_ready_before_issue", 32'(bus.op_ready), 32'd1);
        bus.op_valid = 1'b1;
        bus.op_a = a;
        bus.op_b = b;
        bus.op_s = s;
        bus.op_m = m;
        bus.op_cnb = cnb;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        sb.push_back(model(a, b, s, m, cnb));
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                          input logic m, input logic cnb, output logic [3:0] cn);
        int n = 0;
        logic [17:0] e;
        cn = 4'hx;
        issue(a, b, s, m, cnb);
        while (!bus.res_valid && n < 20) begin
            if (n < 4) cn[n] = alu_cnb;
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 32'(n), 32'd4);
        e = (sb.size() != 0) ? sb.pop_front() : 18'hx;
        chk("res_f", 32'(bus.res_f), 32'(e[17:2]));
        chk("res_cn4b", 32'(bus.res_cn4b), 32'(e[1]));
        chk("res_aeb", 32'(bus.res_aeb), 32'(e[0]));
    endtask

    task automatic accept();
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        chk("res_valid_cleared", 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        chk("op_ready_after_accept", 32'(bus.op_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.op_valid = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;
        bus.op_s = '0;
        bus.op_m = 1'b0;
        bus.op_cnb = 1'b1;
        bus.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_f", 32'(bus.res_f), 32'd0);
        chk("rst_res_cn4b", 32'(bus.res_cn4b), 32'd1);
        chk("rst_res_aeb", 32'(bus.res_aeb), 32'd0);
        chk("rst_alu_m", 32'(alu_m), 32'd1);
        chk("rst_alu_cnb", 32'(alu_cnb), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("op_ready_after_rst", 32'(bus.op_ready), 32'd1);

        run_op(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, cnbs);
        chk("add_value", 32'(bus.res_f), 32'h2233);
        accept();

        run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, cnbs);
        chk("wrap_value", 32'(bus.res_f), 32'h0000);
        chk("wrap_cn4b", 32'(bus.res_cn4b), 32'd0);
        chk("wrap_carry_chain", 32'(cnbs), 32'b0001);
        accept();

        run_op(16'hBEEF, 16'hBEEF, 4'b0110, 1'b0, 1'b1, cnbs);
        chk("eq_value", 32'(bus.res_f), 32'hFFFF);
        chk("eq_aeb", 32'(bus.res_aeb), 32'd1);
        accept();

        run_op(16'hBEEF, 16'hBEEE, 4'b0110, 1'b0, 1'b1, cnbs);
        chk("ne_aeb", 32'(bus.res_aeb), 32'd0);
        accept();

        run_op(16'hF0F0, 16'h3C3C, 4'b1011, 1'b1, 1'b1, cnbs);
        chk("and_value", 32'(bus.res_f), 32'h3030);
        accept();

        run_op(16'h5A5A, 16'h0F0F, 4'b0110, 1'b1, 1'b0, cnbs);
        accept();

        run_op(16'h7777, 16'h1111, 4'b1001, 1'b0, 1'b0, cnbs);
        held = bus.res_f;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.op_valid = 1'b1;
            bus.op_a = 16'($urandom);
            bus.op_b = 16'($urandom);
            chk("bp_res_valid", 32'(bus.res_valid), 32'd1);
            chk("bp_res_f", 32'(bus.res_f), 32'(held));
            chk("bp_op_ready", 32'(bus.op_ready), 32'd0);
            chk("bp_alu_m_idle", 32'(alu_m), 32'd1);
        end
        bus.op_valid = 1'b0;
        accept();
        chk("bp_no_extra_result", 32'(bus.res_valid), 32'd0);

        issue(16'h5555, 16'h1111, 4'b1001, 1'b0, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        chk("midrst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("midrst_res_f", 32'(bus.res_f), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_op_ready", 32'(bus.op_ready), 32'd1);
        chk("midrst_res_valid_after", 32'(bus.res_valid), 32'd0);
        run_op(16'h0001, 16'h0001, 4'b1001, 1'b0, 1'b1, cnbs);
        chk("post_rst_add", 32'(bus.res_f), 32'h0002);
        accept();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
